// File: rtl/bank_reader_pkg.sv
// Shared definitions for the register bank and its reader: state encoding,
// bank geometry defaults and the index width.
package bank_reader_pkg;

    localparam int NREG_DEF = 4;
    localparam int W_DEF    = 8;
    localparam int IDX_W    = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/bank_reader.sv
// Reads a four-register bank either one word at a time or as a four-word burst.
// The bank is snapshotted on acceptance and words leave over a valid/ready port.
module bank_reader
    import bank_reader_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int W    = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     q3,
    input  logic [W-1:0]     q2,
    input  logic [W-1:0]     q1,
    input  logic [W-1:0]     q0,
    input  logic             rd,
    input  logic [IDX_W-1:0] addr,
    input  logic             burst,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [IDX_W-1:0] dout_idx,
    output logic             last,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             burst_q, burst_d;
    logic             capture;
    logic [W-1:0]     snap_q [NREG];
    logic [W-1:0]     bank_in [NREG];

    assign bank_in[0] = q0;
    assign bank_in[1] = q1;
    assign bank_in[2] = q2;
    assign bank_in[3] = q3;

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block can leave a signal unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        burst_d    = burst_q;
        capture    = 1'b0;
        dout_valid = 1'b0;
        dout       = '0;
        last       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd || burst) begin
                    state_d = ST_SEND;
                    capture = 1'b1;
                    burst_d = burst;
                    idx_d   = burst ? '0 : addr;
                end
            end
            ST_SEND: begin
                dout_valid = 1'b1;
                dout       = snap_q[idx_q];
                last       = !burst_q || (idx_q == IDX_W'(NREG - 1));
                if (dout_ready) begin
                    if (last) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dout_idx = idx_q;
    assign busy     = (state_q != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments only; the snapshot
    // buffer is small enough to be flops, so it is cleared by reset like the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            burst_q <= 1'b0;
            for (int i = 0; i < NREG; i++) snap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            burst_q <= burst_d;
            if (capture) begin
                for (int i = 0; i < NREG; i++) snap_q[i] <= bank_in[i];
            end
        end
    end

endmodule
